// File: rtl/traffic_light_ctrl_param_pkg.sv
// Shared state encoding and lamp patterns for the parametrised NS/EW traffic-light controller.
// Lamp vectors are ordered {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GRN = 3'd0,
        NS_YEL = 3'd1,
        AR1    = 3'd2,
        EW_GRN = 3'd3,
        EW_YEL = 3'd4,
        AR2    = 3'd5,
        FLASH  = 3'd6
    } state_e;

    localparam logic [5:0] LAMP_NS_GRN  = 6'b100_001;
    localparam logic [5:0] LAMP_NS_YEL  = 6'b010_001;
    localparam logic [5:0] LAMP_ALL_RED = 6'b001_001;
    localparam logic [5:0] LAMP_EW_GRN  = 6'b001_100;
    localparam logic [5:0] LAMP_EW_YEL  = 6'b001_010;

    // The unused encoding decodes to all-red so a corrupted state never shows a green.
    function automatic logic [5:0] lamp_decode(state_e s, logic flash);
        case (s)
            NS_GRN:   return LAMP_NS_GRN;
            NS_YEL:   return LAMP_NS_YEL;
            AR1, AR2: return LAMP_ALL_RED;
            EW_GRN:   return LAMP_EW_GRN;
            EW_YEL:   return LAMP_EW_YEL;
            FLASH:    return {1'b0, flash, 1'b0, 1'b0, 1'b0, flash};
            default:  return LAMP_ALL_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_param_if.sv
// Signal bundle between the board switches/sensors, the lamp drivers and the debug display.
interface traffic_light_ctrl_param_if #(
    parameter int CNT_W = 8
);
    // req and night are plain levels sampled on every rising clock edge; there is no
    // valid/ready handshake, and all outputs are valid every cycle after reset.
    logic             req;
    logic             night;
    logic             ns_g;
    logic             ns_y;
    logic             ns_r;
    logic             ew_g;
    logic             ew_y;
    logic             ew_r;
    logic [2:0]       phase;
    logic [CNT_W-1:0] cnt;
    logic             req_pending;

    modport master (
        output req, night,
        input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, phase, cnt, req_pending
    );

    modport slave (
        input  req, night,
        output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, phase, cnt, req_pending
    );

endinterface

// File: rtl/traffic_light_ctrl_param_phase_timer.sv
// Per-phase cycle counter: clears on request, flags the last cycle of a phase of length
// limit_i, and optionally parks on that last cycle instead of counting on.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             sat_en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done_o = (cnt_q == (limit_i - ONE));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q + ONE;
        if (clr_i) begin
            cnt_d = '0;
        end else if (sat_en_i && done_o) begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// Two-road traffic-light controller: NS green rests until EW demand, all-red clearances
// between greens, and a night flashing mode entered from either clearance.
module traffic_light_ctrl_param
    import traffic_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int NS_GREEN  = 6,
    parameter int NS_YELLOW = 2,
    parameter int EW_GREEN  = 3,
    parameter int EW_YELLOW = 2,
    parameter int ALL_RED   = 1,
    parameter int FLASH_DIV = 4
) (
    input logic                      clk,
    input logic                      rst,
    traffic_light_ctrl_param_if.slave bus
);

    localparam longint MAX_D = longint'(1) << CNT_W;

    if (NS_GREEN  < 1 || longint'(NS_GREEN)  >= MAX_D ||
        NS_YELLOW < 1 || longint'(NS_YELLOW) >= MAX_D ||
        EW_GREEN  < 1 || longint'(EW_GREEN)  >= MAX_D ||
        EW_YELLOW < 1 || longint'(EW_YELLOW) >= MAX_D ||
        ALL_RED   < 1 || longint'(ALL_RED)   >= MAX_D ||
        FLASH_DIV < 1 || longint'(FLASH_DIV) >= MAX_D) begin : g_bad_params
        $fatal(1, "traffic_light_ctrl_param: a phase duration is outside 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] L_NS_GRN  = CNT_W'(NS_GREEN);
    localparam logic [CNT_W-1:0] L_NS_YEL  = CNT_W'(NS_YELLOW);
    localparam logic [CNT_W-1:0] L_EW_GRN  = CNT_W'(EW_GREEN);
    localparam logic [CNT_W-1:0] L_EW_YEL  = CNT_W'(EW_YELLOW);
    localparam logic [CNT_W-1:0] L_ALL_RED = CNT_W'(ALL_RED);
    localparam logic [CNT_W-1:0] L_FLASH   = CNT_W'(FLASH_DIV);

    state_e           state_q;
    state_e           state_d;
    logic             req_pending_q;
    logic             req_pending_d;
    logic             flash_q;
    logic             flash_d;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             entering;
    logic             timer_clr;
    logic [5:0]       lamps;

    assign entering  = (state_d != state_q);
    // FLASH reuses the timer as a free-running divider, so each wrap also clears it.
    assign timer_clr = entering || ((state_q == FLASH) && done);

    always_comb begin
        case (state_q)
            NS_GRN:   limit = L_NS_GRN;
            NS_YEL:   limit = L_NS_YEL;
            AR1, AR2: limit = L_ALL_RED;
            EW_GRN:   limit = L_EW_GRN;
            EW_YEL:   limit = L_EW_YEL;
            default:  limit = L_FLASH;
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (timer_clr),
        .sat_en_i (state_q == NS_GRN),
        .limit_i  (limit),
        .cnt_o    (cnt),
        .done_o   (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NS_GRN;
            req_pending_q <= 1'b0;
            flash_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_pending_q <= req_pending_d;
            flash_q       <= flash_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_GRN: if (done && (req_pending_q || bus.night)) state_d = NS_YEL;
            NS_YEL: if (done) state_d = AR1;
            AR1:    if (done) state_d = bus.night ? FLASH : EW_GRN;
            EW_GRN: if (done) state_d = EW_YEL;
            EW_YEL: if (done) state_d = AR2;
            AR2:    if (done) state_d = bus.night ? FLASH : NS_GRN;
            FLASH:  if (done && !bus.night) state_d = AR2;
            default: state_d = NS_GRN;
        endcase
    end

    // Entering EW_GRN serves the demand, and that clear beats a request on the same edge.
    always_comb begin
        req_pending_d = req_pending_q;
        if (state_d == EW_GRN && state_q != EW_GRN) begin
            req_pending_d = 1'b0;
        end else if (bus.req && state_q != EW_GRN) begin
            req_pending_d = 1'b1;
        end
    end

    always_comb begin
        flash_d = flash_q;
        if (state_d == FLASH && state_q != FLASH) begin
            flash_d = 1'b1;
        end else if (state_q == FLASH && done) begin
            flash_d = ~flash_q;
        end
    end

    always_comb begin
        lamps = lamp_decode(state_q, flash_q);
        {bus.ns_g, bus.ns_y, bus.ns_r, bus.ew_g, bus.ew_y, bus.ew_r} = lamps;
        bus.phase       = state_q;
        bus.cnt         = cnt;
        bus.req_pending = req_pending_q;
    end

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Self-checking bench for traffic_light_ctrl_param against a table-driven phase model.
module tb_traffic_light_ctrl_param;

    localparam int CNT_W     = 8;
    localparam int NS_GREEN  = 6;
    localparam int NS_YELLOW = 2;
    localparam int EW_GREEN  = 3;
    localparam int EW_YELLOW = 2;
    localparam int ALL_RED   = 1;
    localparam int FLASH_DIV = 4;
    localparam int VW        = 3 + CNT_W + 1 + 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_light_ctrl_param_if #(.CNT_W(CNT_W)) bus ();

    traffic_light_ctrl_param #(
        .CNT_W(CNT_W), .NS_GREEN(NS_GREEN), .NS_YELLOW(NS_YELLOW), .EW_GREEN(EW_GREEN),
        .EW_YELLOW(EW_YELLOW), .ALL_RED(ALL_RED), .FLASH_DIV(FLASH_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: phase index, cycles spent in phase, latched demand, flash lamp.
    int dur [7] = '{NS_GREEN, NS_YELLOW, ALL_RED, EW_GREEN, EW_YELLOW, ALL_RED, FLASH_DIV};
    int m_ph;
    int m_cnt;
    bit m_pend;
    bit m_flash;

    function automatic void model_reset();
        m_ph = 0; m_cnt = 0; m_pend = 1'b0; m_flash = 1'b0;
    endfunction

    function automatic void model_step(bit r, bit n);
        int nx;
        bit last;
        last = (m_cnt == dur[m_ph] - 1);
        nx = m_ph;
        if (last) begin
            case (m_ph)
                0: if (m_pend || n) nx = 1;
                2: nx = n ? 6 : 3;
                5: nx = n ? 6 : 0;
                6: if (!n) nx = 5;
                default: nx = m_ph + 1;
            endcase
        end
        if (nx == 3 && m_ph != 3) m_pend = 1'b0;
        else if (r && m_ph != 3) m_pend = 1'b1;
        if (nx == 6 && m_ph != 6) m_flash = 1'b1;
        else if (m_ph == 6 && last) m_flash = !m_flash;
        if (nx != m_ph || (m_ph == 6 && last)) m_cnt = 0;
        else if (!(m_ph == 0 && last)) m_cnt = m_cnt + 1;
        m_ph = nx;
    endfunction

    function automatic logic [5:0] model_lamps();
        case (m_ph)
            0: return 6'b100_001;
            1: return 6'b010_001;
            3: return 6'b001_100;
            4: return 6'b001_010;
            6: return {1'b0, m_flash, 3'b000, m_flash};
            default: return 6'b001_001;
        endcase
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {3'(m_ph), CNT_W'(m_cnt), m_pend, model_lamps()};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.phase, bus.cnt, bus.req_pending,
                bus.ns_g, bus.ns_y, bus.ns_r, bus.ew_g, bus.ew_y, bus.ew_r};
    endfunction

    task automatic cycle(bit r, bit n, bit rs);
        bus.req = r;
        bus.night = n;
        rst = rs;
        if (rs) model_reset();
        else model_step(r, n);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && bus.phase != 3'd6) begin
            checks++;
            if (!$onehot({bus.ns_g, bus.ns_y, bus.ns_r}) || !$onehot({bus.ew_g, bus.ew_y, bus.ew_r})) begin
                errors++;
                $display("FAIL lamp_onehot t=%0t ns=%b ew=%b required one lamp per road", $time,
                         {bus.ns_g, bus.ns_y, bus.ns_r}, {bus.ew_g, bus.ew_y, bus.ew_r});
            end
        end
    end

    task automatic test_reset();
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        checks++;
        if (obs_vec() !== {3'd0, CNT_W'(0), 1'b0, 6'b100_001}) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", obs_vec(), {3'd0, CNT_W'(0), 1'b0, 6'b100_001});
        end
        mon_en = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) begin
            cycle(0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL idle cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.cnt !== CNT_W'(NS_GREEN - 1) || bus.phase !== 3'd0) begin
            errors++;
            $display("FAIL idle_saturate cnt=%0d phase=%0d exp cnt=%0d phase=0", bus.cnt, bus.phase, NS_GREEN - 1);
        end
    endtask

    task automatic test_req_pulse();
        logic [2:0] exp_ph [12];
        exp_ph = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0, 3'd0};
        for (int k = 0; k < 12; k++) begin
            cycle(k == 0, 0, 0);
            checks++;
            if (bus.phase !== exp_ph[k] || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL req_pulse k=%0d phase=%0d exp_phase=%0d got=%h exp=%h",
                         k, bus.phase, exp_ph[k], obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_req_held();
        logic [2:0] hist [60];
        for (int i = 0; i < 60; i++) begin
            cycle(1, 0, 0);
            hist[i] = bus.phase;
            checks++;
            if (obs_vec() !== exp_vec() || (bus.phase == 3'd3 && bus.req_pending !== 1'b0)) begin
                errors++;
                $display("FAIL req_held cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 20; i < 45; i++) begin
            checks++;
            if (hist[i] !== hist[i + 15]) begin
                errors++;
                $display("FAIL period15 i=%0d phase=%0d phase_plus15=%0d", i, hist[i], hist[i + 15]);
            end
        end
    endtask

    task automatic test_night();
        int budget;
        int fk;
        int ar2_cycles;
        budget = 40;
        while (m_ph != 3 && budget > 0) begin
            cycle(1, 0, 0);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL night_reach_ew phase=%0d exp=3", bus.phase);
        end
        fk = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL night cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (bus.phase == 3'd6 && fk < 8) begin
                checks++;
                if (bus.ns_y !== ((fk / FLASH_DIV) % 2 == 0) || bus.ew_r !== bus.ns_y ||
                    {bus.ns_g, bus.ns_r, bus.ew_g, bus.ew_y} !== 4'b0000) begin
                    errors++;
                    $display("FAIL flash_pattern k=%0d ns_y=%b ew_r=%b exp=%b", fk, bus.ns_y, bus.ew_r,
                             ((fk / FLASH_DIV) % 2 == 0));
                end
                fk++;
            end
        end
        checks++;
        if (fk != 8) begin
            errors++;
            $display("FAIL flash_entered flash_cycles=%0d exp=8", fk);
        end
        budget = 20;
        while (!(m_ph == 6 && m_cnt == 1) && budget > 0) begin
            cycle(0, 1, 0);
            budget--;
        end
        ar2_cycles = 0;
        budget = 20;
        while (m_ph != 0 && budget > 0) begin
            cycle(0, 0, 0);
            budget--;
            if (bus.phase == 3'd5) ar2_cycles++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL night_exit got=%h exp=%h", obs_vec(), exp_vec());
            end
        end
        checks++;
        if (budget == 0 || ar2_cycles != ALL_RED || bus.phase !== 3'd0) begin
            errors++;
            $display("FAIL night_exit_seq ar2_cycles=%0d exp=%0d phase=%0d exp=0", ar2_cycles, ALL_RED, bus.phase);
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        budget = 40;
        while (!(m_ph == 4 && m_cnt == 1) && budget > 0) begin
            cycle(1, 0, 0);
            budget--;
        end
        checks++;
        if (budget == 0 || bus.phase !== 3'd4 || bus.cnt !== CNT_W'(1) || bus.req_pending !== 1'b1) begin
            errors++;
            $display("FAIL reach_ew_yel phase=%0d cnt=%0d pend=%b exp 4/1/1", bus.phase, bus.cnt, bus.req_pending);
        end
        cycle(1, 0, 1);
        checks++;
        if (obs_vec() !== {3'd0, CNT_W'(0), 1'b0, 6'b100_001}) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h", obs_vec(), {3'd0, CNT_W'(0), 1'b0, 6'b100_001});
        end
    endtask

    task automatic test_random();
        bit n;
        n = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) n = !n;
            cycle($urandom_range(0, 3) == 0, n, $urandom_range(0, 99) == 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = 1'b0;
        bus.night = 1'b0;
        model_reset();
        test_reset();
        test_idle();
        test_req_pulse();
        test_req_held();
        test_night();
        test_reset_mid();
        test_random();
        cycle(0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl_param.md
Name: traffic_light_ctrl_param

Overview:
Parametrised successor of the two-road (NS/EW) traffic-light controller. Phase durations are set by parameters, and the NS-green rest phase is held until an EW demand request arrives. Adds all-red clearance intervals and a night flashing mode. Sits between the board switch/sensor inputs and the six lamp outputs; exposes phase and counter for LED/7-seg debug.

Parameters:
CNT_W, 8, width of phase counter
NS_GREEN, 6, minimum NS green cycles (rest phase)
NS_YELLOW, 2, NS yellow cycles
EW_GREEN, 3, EW green cycles
EW_YELLOW, 2, EW yellow cycles
ALL_RED, 1, all-red clearance cycles (both clearances)
FLASH_DIV, 4, cycles per flash half-period in night mode

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  1  EW demand (switch/sensor), level, latched internally
night  in  1  night-mode request, level
ns_g, ns_y, ns_r  out  1 each  NS lamps
ew_g, ew_y, ew_r  out  1 each  EW lamps
phase  out  3  current state encoding
cnt  out  CNT_W  current phase counter
req_pending  out  1  latched EW demand

Behaviour:
- Reset (rst=1 at edge): state=NS_GRN, cnt=0, req_pending=0, flash=0. Outputs ns_g=1, ew_r=1, others 0. Reset mid-phase aborts the phase immediately.
- Lamps are a pure decode of registered state/flash. They change on the same edge the state changes, with no extra latency. Exactly one NS lamp and one EW lamp are on, except in FLASH.
- States: NS_GRN(0), NS_YEL(1), AR1(2), EW_GRN(3), EW_YEL(4), AR2(5), FLASH(6).
- Lamp decode:
  - NS_GRN: ns_g, ew_r
  - NS_YEL: ns_y, ew_r
  - AR1/AR2: ns_r, ew_r
  - EW_GRN: ns_r, ew_g
  - EW_YEL: ns_r, ew_y
  - FLASH: ns_y=flash, ew_r=flash, rest 0
- cnt resets to 0 on every state entry. A timed state of duration D advances on the edge where cnt==D-1, so it lasts exactly D cycles.
- NS_GRN: cnt saturates at NS_GREEN-1. Leave to NS_YEL on the edge where cnt==NS_GREEN-1 and (req_pending or night). Otherwise hold indefinitely.
- NS_YEL→AR1→EW_GRN→EW_YEL→AR2→NS_GRN, each timed.
- At end of AR1 or AR2: if night=1, go to FLASH instead of the next green.
- req_pending:
  - Set on any edge with req=1, except while state==EW_GRN.
  - Cleared on the edge entering EW_GRN; the clear wins over a simultaneous req.
  - Requests during EW_YEL/AR2 stay latched and are served in the next cycle.
- FLASH:
  - cnt counts 0..FLASH_DIV-1 and wraps.
  - flash toggles at each wrap; flash=1 on FLASH entry.
  - When night=0 at a wrap edge, go to AR2 and then NS_GRN.
- Full cycle with req held high: 6+2+1+3+2+1 = 15 cycles.
- Elaboration check: every duration ≥1 and <2^CNT_W; FLASH_DIV ≥1. Violation is a fatal error.
- The counter never wraps in timed states: comparison is against D-1 only, and saturation applies in NS_GRN.

Decomposition:
- Package traffic_pkg holds:
  - state encoding constants (NS_GRN..FLASH, 3-bit)
  - lamp-vector constants {ns_g,ns_y,ns_r,ew_g,ew_y,ew_r} per state
- Sub-module phase_timer (CNT_W):
  - inputs: clr, limit, sat_en
  - outputs: cnt, done (cnt==limit-1); saturates at limit-1 when sat_en
- Top holds the FSM, request latch and flash toggle.

Test Plan:
- Reset then req=0 for 50 cycles: state stays NS_GRN, cnt sticks at 5, ns_g=1/ew_r=1 throughout, req_pending=0.
- req pulsed 1 cycle at cycle 10: req_pending=1. NS_YEL on edge 11, AR1 at 13, EW_GRN at 14 (req_pending→0), EW_YEL at 17, AR2 at 19, NS_GRN at 20.
- req held high continuously: periodic 15-cycle sequence, and req during EW_GRN does not set req_pending. Also assert req on the edge entering EW_GRN: req_pending=0 afterwards.
- night=1 during EW_GRN: sequence completes EW_YEL, AR2, then FLASH. ns_y/ew_r toggle every 4 cycles, starting at 1, and other lamps stay 0.
- night→0 mid-flash-period: exit only at the next wrap, then 1 cycle all-red, then NS_GRN.
- rst asserted during EW_YEL, cnt=1: next edge gives NS_GRN, cnt=0, req_pending=0, lamps ns_g/ew_r. Lamp one-hot-per-road assertion checked every cycle outside FLASH.
